// File: rtl/ow_txn_scheduler.sv
// ow_txn_scheduler
// Sits between two host requesters and the single 1-wire bit-level engine.
// It picks a requester round-robin and expands its byte-level command
// (bus reset/presence, write byte, read byte) into bit primitives. It also
// assembles read bits LSB-first, catches engine timeouts and answers each
// request with exactly one ack pulse.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-low reset
//   req[1:0]              pending command per requester
//   cmd0/cmd1, wdata0/1   command and write byte per requester
//   ack[1:0]              one-cycle completion pulse to the granted requester
//   rdata, status         result of the last transaction, held until the next one
//   busy                  high whenever the scheduler is not idle
//   bit_start/op/wval     primitive request to the bit engine
//   bit_done/rval,presence primitive completion from the bit engine
//   dbg_state             current FSM state, for checkers
//
// Handshake: requester i raises req[i] with stable cmd/wdata and holds it
// until ack[i]. The request is latched at grant, so later req/cmd/wdata
// changes do not disturb the running transaction. Toward the engine,
// bit_start pulses once per primitive; bit_op/bit_wval stay stable until the
// matching bit_done pulse. A bit_done outside WAIT is ignored.
module ow_txn_scheduler #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] cmd0,
  input  logic [1:0] cmd1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [7:0] rdata,
  output logic [1:0] status,
  output logic       busy,
  output logic       bit_start,
  output logic [1:0] bit_op,
  output logic       bit_wval,
  input  logic       bit_done,
  input  logic       bit_rval,
  input  logic       presence,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Timeout fires on the WAIT cycle whose increment would reach TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYC - 2);

  localparam logic [1:0] CMD_RST = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NOPRES  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [1:0]       status_q, status_d;

  // Round-robin: a lone requester wins outright; on contention the one
  // that was not granted last time wins.
  logic       pick;
  logic [1:0] pick_cmd;
  logic [7:0] pick_wdata;
  assign pick       = (req == 2'b11) ? ~last_grant_q : req[1];
  assign pick_cmd   = pick ? cmd1 : cmd0;
  assign pick_wdata = pick ? wdata1 : wdata0;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant_d      = pick;
          last_grant_d = pick;
          cmd_d        = pick_cmd;
          wdata_d      = pick_wdata;
          bit_idx_d    = 3'd0;
          shift_d      = 8'h00;
          if (pick_cmd == CMD_ILL) begin
            status_d = ST_ILLEGAL;
            rdata_d  = 8'h00;
            state_d  = S_RESP;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bit_done) begin
          if (cmd_q == CMD_RST) begin
            status_d = presence ? ST_OK : ST_NOPRES;
            rdata_d  = 8'h00;
            state_d  = S_RESP;
          end else begin
            if (cmd_q == CMD_RD) begin
              shift_d = {bit_rval, shift_q[7:1]};
            end
            if (bit_idx_q == 3'd7) begin
              status_d = ST_OK;
              // shift_d already holds the final bit, so rdata is ready with ack.
              rdata_d  = (cmd_q == CMD_RD) ? shift_d : 8'h00;
              state_d  = S_RESP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              state_d   = S_ISSUE;
            end
          end
        end else if (cnt_q == CNT_FIRE) begin
          status_d = ST_TIMEOUT;
          rdata_d  = 8'h00;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_q        <= 2'b00;
      wdata_q      <= 8'h00;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      cnt_q        <= '0;
      rdata_q      <= 8'h00;
      status_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
    end
  end

  // Engine-facing outputs are decoded from the registered state, so they
  // are glitch-free and hold steady for the whole ISSUE/WAIT span.
  logic in_bit;
  assign in_bit    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bit_start = (state_q == S_ISSUE);
  assign bit_op    = !in_bit ? 2'b00 :
                     (cmd_q == CMD_RD) ? 2'b10 :
                     (cmd_q == CMD_WR) ? 2'b01 : 2'b00;
  assign bit_wval  = in_bit ? wdata_q[bit_idx_q] : 1'b0;
  assign ack       = (state_q != S_RESP) ? 2'b00 : (grant_q ? 2'b10 : 2'b01);
  assign busy      = (state_q != S_IDLE);
  assign rdata     = rdata_q;
  assign status    = status_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ow_txn_scheduler.sv
// Bench for ow_txn_scheduler: a behavioural bit engine answers primitives
// after a programmable delay; scenario tasks compare against expectations
// derived from the command rules (bits LSB-first, round-robin, latencies).
module tb_ow_txn_scheduler;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] cmd0 = 2'b00, cmd1 = 2'b00;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic [1:0] ack, status, bit_op, dbg_state;
  logic [7:0] rdata;
  logic       busy, bit_start, bit_wval;
  logic       bit_done = 1'b0, bit_rval = 1'b0, presence = 1'b0;

  ow_txn_scheduler #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata),
    .status(status), .busy(busy), .bit_start(bit_start), .bit_op(bit_op),
    .bit_wval(bit_wval), .bit_done(bit_done), .bit_rval(bit_rval),
    .presence(presence), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic model_last = 1'b1;   // reference round-robin pointer
  logic [7:0] exp_q[$];      // expected {op, wval} per primitive

  // ---------------- behavioural bit engine ----------------
  int         eng_delay = 1;
  int         eng_limit = 100;   // primitives answered per transaction
  int         eng_base  = 0;
  int         stray_at  = -1;
  logic [7:0] eng_rbyte = 8'h00;
  logic       eng_presence = 1'b1;
  int         eng_cnt = 0;
  int         eng_cur = 0;
  logic [1:0] st_op_q[$];
  logic       st_wval_q[$];
  int         st_cyc_q[$];

  always @(negedge clk) begin
    bit_done = 1'b0;
    if (bit_start) begin
      st_op_q.push_back(bit_op);
      st_wval_q.push_back(bit_wval);
      st_cyc_q.push_back(cyc);
    end
    if (!reset) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) begin
          bit_done = 1'b1;
          bit_rval = eng_rbyte[eng_cur[2:0]];
          presence = eng_presence;
        end
      end
      if (cyc == stray_at) bit_done = 1'b1;
      if (bit_start && (st_op_q.size() - eng_base <= eng_limit)) begin
        eng_cnt = eng_delay;
        eng_cur = st_op_q.size() - 1 - eng_base;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_txn(input logic [1:0] r, input logic [1:0] c0, input logic [1:0] c1,
                           input logic [7:0] w0, input logic [7:0] w1,
                           output int c, output int base);
    @(negedge clk);
    cmd0 = c0; cmd1 = c1; wdata0 = w0; wdata1 = w1; req = r;
    c = cyc;
    base = st_op_q.size();
    eng_base = base;
  endtask

  task automatic wait_ack(output logic got, output logic [1:0] a, output logic [1:0] st,
                          output logic [7:0] rd, output int at);
    got = 1'b0; a = 2'b00; st = 2'b00; rd = 8'h00; at = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        got = 1'b1; a = ack; st = status; rd = rdata; at = cyc;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ack !== 2'b00)    $display("FAIL rst_ack: got %0h exp 0", ack); else n_pass++;
    n_checks++; if (bit_start !== 1'b0) $display("FAIL rst_bit_start: got %0h exp 0", bit_start); else n_pass++;
    n_checks++; if (bit_op !== 2'b00) $display("FAIL rst_bit_op: got %0h exp 0", bit_op); else n_pass++;
    n_checks++; if (bit_wval !== 1'b0) $display("FAIL rst_bit_wval: got %0h exp 0", bit_wval); else n_pass++;
    n_checks++; if (rdata !== 8'h00)  $display("FAIL rst_rdata: got %0h exp 0", rdata); else n_pass++;
    n_checks++; if (status !== 2'b00) $display("FAIL rst_status: got %0h exp 0", status); else n_pass++;
    n_checks++; if (busy !== 1'b0)    $display("FAIL rst_busy: got %0h exp 0", busy); else n_pass++;
    reset = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_write_byte;
    int c, base, at, n; logic got; logic [1:0] a, st; logic [7:0] rd;
    logic [7:0] wd = 8'hA5;
    eng_delay = 3; eng_limit = 100;
    start_txn(2'b01, 2'b01, 2'b10, wd, 8'h3C, c, base);
    wait_ack(got, a, st, rd, at);
    req = 2'b00; model_last = 1'b0;
    n_checks++; if (!got) $display("FAIL wr_ack_seen: got none exp ack"); else n_pass++;
    n = st_op_q.size() - base;
    n_checks++; if (n != 8) $display("FAIL wr_nbits: got %0d exp 8", n); else n_pass++;
    for (int i = 0; i < 8 && i < n; i++) begin
      n_checks++;
      if (st_op_q[base+i] !== 2'b01 || st_wval_q[base+i] !== wd[i])
        $display("FAIL wr_bit%0d: got op %0h wval %0h exp op 1 wval %0h", i, st_op_q[base+i], st_wval_q[base+i], wd[i]);
      else n_pass++;
    end
    n_checks++; if (a !== 2'b01)  $display("FAIL wr_ack: got %0h exp 1", a); else n_pass++;
    n_checks++; if (st !== 2'b00) $display("FAIL wr_status: got %0h exp 0", st); else n_pass++;
    n_checks++; if (n > 0 && st_cyc_q[base] != c + 1) $display("FAIL wr_first_start: got %0d exp %0d", st_cyc_q[base], c + 1); else n_pass++;
    n_checks++; if (at != c + 33) $display("FAIL wr_latency: got %0d exp %0d", at, c + 33); else n_pass++;
    @(negedge clk);
    n_checks++; if (ack !== 2'b00 || busy !== 1'b0) $display("FAIL wr_after: got ack %0h busy %0h exp 0 0", ack, busy); else n_pass++;
  endtask

  task automatic test_read_byte;
    int c, base, at, n; logic got; logic [1:0] a, st; logic [7:0] rd;
    eng_delay = 1; eng_rbyte = 8'hAA;
    start_txn(2'b10, 2'b01, 2'b10, 8'hFF, 8'h00, c, base);
    wait_ack(got, a, st, rd, at);
    req = 2'b00; model_last = 1'b1;
    n = st_op_q.size() - base;
    n_checks++; if (n != 8) $display("FAIL rd_nbits: got %0d exp 8", n); else n_pass++;
    for (int i = 0; i < 8 && i < n; i++) begin
      n_checks++; if (st_op_q[base+i] !== 2'b10) $display("FAIL rd_op%0d: got %0h exp 2", i, st_op_q[base+i]); else n_pass++;
    end
    n_checks++; if (rd !== 8'hAA) $display("FAIL rd_rdata: got %0h exp aa", rd); else n_pass++;
    n_checks++; if (a !== 2'b10)  $display("FAIL rd_ack: got %0h exp 2", a); else n_pass++;
    n_checks++; if (st !== 2'b00) $display("FAIL rd_status: got %0h exp 0", st); else n_pass++;
    n_checks++; if (at != c + 17) $display("FAIL rd_latency: got %0d exp %0d", at, c + 17); else n_pass++;
  endtask

  task automatic test_random;
    int c, base, at, n, r, d, exp_lat; logic got; logic [1:0] a, st, cm, exp_st;
    logic [7:0] rd, w, rb, exp_rd, e; logic pr;
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 1); cm = 2'($urandom_range(0, 2)); w = 8'($urandom);
      rb = 8'($urandom); pr = 1'($urandom_range(0, 1)); d = $urandom_range(1, 4);
      eng_delay = d; eng_rbyte = rb; eng_presence = pr; eng_limit = 100;
      // reference: what the command should produce at byte level
      exp_q.delete();
      if (cm == 2'b00) exp_q.push_back(8'h00);
      else for (int i = 0; i < 8; i++) exp_q.push_back({5'b0, cm, (cm == 2'b01) ? w[i] : 1'b0});
      exp_st  = (cm == 2'b00 && !pr) ? 2'b01 : 2'b00;
      exp_rd  = (cm == 2'b10) ? rb : 8'h00;
      exp_lat = (cm == 2'b00) ? d + 2 : 8 * (d + 1) + 1;
      if (r == 0) start_txn(2'b01, cm, 2'b11, w, ~w, c, base);
      else        start_txn(2'b10, 2'b11, cm, ~w, w, c, base);
      wait_ack(got, a, st, rd, at);
      req = 2'b00; model_last = r[0];
      n = st_op_q.size() - base;
      n_checks++; if (n != exp_q.size()) $display("FAIL rnd%0d_nbits: got %0d exp %0d", k, n, exp_q.size()); else n_pass++;
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
        e = {5'b0, st_op_q[base+i], (cm == 2'b01) ? st_wval_q[base+i] : 1'b0};
        n_checks++; if (e !== exp_q[i]) $display("FAIL rnd%0d_bit%0d: got %0h exp %0h", k, i, e, exp_q[i]); else n_pass++;
      end
      n_checks++; if (a !== (r ? 2'b10 : 2'b01)) $display("FAIL rnd%0d_ack: got %0h exp %0h", k, a, r ? 2'b10 : 2'b01); else n_pass++;
      n_checks++; if (st !== exp_st) $display("FAIL rnd%0d_status: got %0h exp %0h", k, st, exp_st); else n_pass++;
      n_checks++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata: got %0h exp %0h", k, rd, exp_rd); else n_pass++;
      n_checks++; if (at != c + exp_lat) $display("FAIL rnd%0d_latency: got %0d exp %0d", k, at, c + exp_lat); else n_pass++;
    end
  endtask

  task automatic test_arbitration;
    int c, base, at; logic got, exp_g; logic [1:0] a, st; logic [7:0] rd;
    eng_delay = 2; eng_presence = 1'b1;
    start_txn(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, c, base);
    for (int k = 0; k < 4; k++) begin
      exp_g = ~model_last;
      wait_ack(got, a, st, rd, at);
      if (k == 3) req = 2'b00;
      n_checks++; if (a !== (exp_g ? 2'b10 : 2'b01)) $display("FAIL arb%0d_grant: got %0h exp %0h", k, a, exp_g ? 2'b10 : 2'b01); else n_pass++;
      n_checks++; if (st !== 2'b00) $display("FAIL arb%0d_status: got %0h exp 0", k, st); else n_pass++;
      model_last = exp_g;
    end
    eng_presence = 1'b0;
    start_txn(2'b10, 2'b01, 2'b00, 8'h00, 8'h00, c, base);
    wait_ack(got, a, st, rd, at);
    req = 2'b00; model_last = 1'b1;
    n_checks++; if (a !== 2'b10 || st !== 2'b01) $display("FAIL arb_nopres: got ack %0h status %0h exp 2 1", a, st); else n_pass++;
    eng_presence = 1'b1;
  endtask

  task automatic test_timeout;
    int c, base, at, n; logic got; logic [1:0] a, st; logic [7:0] rd;
    eng_delay = 1; eng_limit = 3; eng_rbyte = 8'hFF;
    start_txn(2'b01, 2'b10, 2'b00, 8'h00, 8'h00, c, base);
    wait_ack(got, a, st, rd, at);
    req = 2'b00; model_last = 1'b0;
    n = st_op_q.size() - base;
    n_checks++; if (n != 4) $display("FAIL to_nbits: got %0d exp 4", n); else n_pass++;
    n_checks++; if (n == 4 && at != st_cyc_q[base+3] + TO) $display("FAIL to_latency: got %0d exp %0d", at, st_cyc_q[base+3] + TO); else n_pass++;
    n_checks++; if (st !== 2'b10) $display("FAIL to_status: got %0h exp 2", st); else n_pass++;
    n_checks++; if (rd !== 8'h00) $display("FAIL to_rdata: got %0h exp 0", rd); else n_pass++;
    n_checks++; if (a !== 2'b01)  $display("FAIL to_ack: got %0h exp 1", a); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL to_idle: got busy %0h exp 0", busy); else n_pass++;
    eng_limit = 100;
  endtask

  task automatic test_illegal_stray;
    int c, base, at, busy_seen, s0; logic got; logic [1:0] a, st; logic [7:0] rd;
    start_txn(2'b01, 2'b11, 2'b00, 8'h00, 8'h00, c, base);
    wait_ack(got, a, st, rd, at);
    req = 2'b00; model_last = 1'b0;
    n_checks++; if (at != c + 1) $display("FAIL ill_latency: got %0d exp %0d", at, c + 1); else n_pass++;
    n_checks++; if (st !== 2'b11) $display("FAIL ill_status: got %0h exp 3", st); else n_pass++;
    n_checks++; if (a !== 2'b01)  $display("FAIL ill_ack: got %0h exp 1", a); else n_pass++;
    n_checks++; if (st_op_q.size() != base) $display("FAIL ill_nostart: got %0d exp 0", st_op_q.size() - base); else n_pass++;
    @(negedge clk);
    s0 = st_op_q.size(); stray_at = cyc + 1; busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || ack !== 2'b00) busy_seen++;
    end
    n_checks++; if (busy_seen != 0) $display("FAIL stray_state: got %0d busy/ack cycles exp 0", busy_seen); else n_pass++;
    n_checks++; if (st_op_q.size() != s0) $display("FAIL stray_nostart: got %0d exp 0", st_op_q.size() - s0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int c, base, at, s0; logic got; logic [1:0] a, st; logic [7:0] rd;
    eng_delay = 1; eng_rbyte = 8'h5A;
    start_txn(2'b10, 2'b00, 2'b10, 8'h00, 8'h00, c, base);
    wait_ack(got, a, st, rd, at);
    req = 2'b00;
    n_checks++; if (rd !== 8'h5A) $display("FAIL rm_pre_rdata: got %0h exp 5a", rd); else n_pass++;
    eng_delay = 2;
    start_txn(2'b01, 2'b10, 2'b00, 8'hC3, 8'h00, c, base);
    for (int i = 0; i < 100 && st_op_q.size() - base < 3; i++) @(negedge clk);
    n_checks++; if (st_op_q.size() - base < 3) $display("FAIL rm_progress: got %0d starts exp 3", st_op_q.size() - base); else n_pass++;
    reset = 1'b0; req = 2'b00;
    @(negedge clk);
    n_checks++;
    if (ack !== 2'b00 || bit_start !== 1'b0 || bit_op !== 2'b00 || bit_wval !== 1'b0 ||
        rdata !== 8'h00 || status !== 2'b00 || busy !== 1'b0)
      $display("FAIL rm_outputs: got ack %0h bs %0h op %0h wv %0h rd %0h st %0h busy %0h exp all 0",
               ack, bit_start, bit_op, bit_wval, rdata, status, busy);
    else n_pass++;
    s0 = st_op_q.size();
    @(negedge clk);
    reset = 1'b1; model_last = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (st_op_q.size() != s0 || busy !== 1'b0) $display("FAIL rm_quiet: got %0d starts busy %0h exp 0 0", st_op_q.size() - s0, busy); else n_pass++;
    // pointer back at its reset value: requester 0 must win a tie
    eng_delay = 1; eng_presence = 1'b1;
    start_txn(2'b11, 2'b00, 2'b00, 8'h00, 8'h00, c, base);
    wait_ack(got, a, st, rd, at);
    req = 2'b00;
    n_checks++; if (a !== (model_last ? 2'b01 : 2'b10)) $display("FAIL rm_arb: got %0h exp 1", a); else n_pass++;
    model_last = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write_byte;
    test_read_byte;
    test_random;
    test_arbitration;
    test_timeout;
    test_illegal_stray;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
